fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined ARM core. Holds the PC and issues word fetches to instruction memory over a req/gnt/rvalid interface.
- Buffers returned instructions in a 2-entry queue and hands them to decode, together with PC and PC+8. PC+8 is the value decode drives onto the register file's r15 read-override input.
- Handles decode stalls and branch redirects, including squashing fetches already in flight.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 89 ++++++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // One buffered fetch result: the word address it came from and the instruction.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential fetch stride (one ARM word).
  localparam logic [31:0] PC_INC = 32'd4;

  // Architectural r15 read value is the instruction address plus two words.
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  // Default buffer/credit depth.
  localparam int DEFAULT_DEPTH = 2;

  // Clear the byte-offset bits so the result is a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with push, pop, flush and occupancy count.
// Flush wins over push and pop in the same cycle. The head entry is
// presented combinationally (show-ahead) so the consumer sees it at once.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = 64,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  // Advance a pointer, wrapping at DEPTH (which need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem_reg[rd_ptr_reg];

  // A pop frees the slot a simultaneous push may reuse.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Register pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // One storage register per slot, written when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    // Capture pushed data into this slot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (do_push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
        mem_reg[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over a
// req/gnt/rvalid port, buffers returned words and presents them to decode
// with their PC and PC+8. Redirects flush the buffer and squash every
// fetch still in flight, including one granted in the redirect cycle.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus8_d
);

  // The pending-PC tracker must also hold squashed fetches that are still
  // awaiting their response, so it is sized well beyond DEPTH. Its full flag
  // only bites if memory withholds responses across repeated redirects.
  localparam int TRK_DEPTH = 4 * DEPTH;
  localparam int QCNT_W    = $clog2(DEPTH + 1);
  localparam int TCNT_W    = $clog2(TRK_DEPTH + 1);
  localparam int SUM_W     = TCNT_W + 1;

  logic [31:0]       pc_reg, pc_next;
  logic [TCNT_W-1:0] drop_reg, drop_next;
  logic [TCNT_W-1:0] inflight, inflight_next, live;
  logic [SUM_W-1:0]  credits_used;
  logic              grant, rsp;
  logic              q_push, q_pop, q_full, q_empty;
  logic [QCNT_W-1:0] q_count;
  fetch_entry_t      q_din, q_head;
  logic [31:0]       trk_head_pc;
  logic              trk_full, trk_empty;

  // Credits come from registered state only, so a pop this cycle frees its
  // slot for requesting on the next cycle.
  assign live         = inflight - drop_reg;
  assign credits_used = SUM_W'(live) + SUM_W'(q_count);
  assign imem_req     = reset_n & ~trk_full & (credits_used < SUM_W'(DEPTH));
  assign imem_addr    = pc_reg;

  assign grant = imem_req & imem_gnt;
  // A response with nothing outstanding is stray and ignored.
  assign rsp   = imem_rvalid & ~trk_empty;

  assign inflight_next = inflight + TCNT_W'(grant) - TCNT_W'(rsp);

  // Responses still owed to squashed fetches are discarded, not queued.
  assign q_push = rsp & (drop_reg == '0);
  assign q_pop  = ~q_empty & ~stall_d;
  assign q_din  = '{pc: trk_head_pc, instr: imem_rdata};

  // PC update: redirect beats sequential advance; held while ungranted.
  always_comb begin
    pc_next = pc_reg;
    if (br_taken) begin
      pc_next = word_align(br_target);
    end else if (grant) begin
      pc_next = pc_reg + PC_INC;
    end
  end

  // Drop count: on redirect everything outstanding after this cycle's grant
  // and response becomes stale; otherwise each stale response retires one.
  always_comb begin
    drop_next = drop_reg;
    if (br_taken) begin
      drop_next = inflight_next;
    end else if (rsp && (drop_reg != '0)) begin
      drop_next = drop_reg - TCNT_W'(1);
    end
  end

  // Register PC and drop count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg   <= word_align(RESET_PC);
      drop_reg <= '0;
    end else begin
      pc_reg   <= pc_next;
      drop_reg <= drop_next;
    end
  end

  // Decoded instruction buffer; redirect flushes it.
  fetch_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_queue (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (br_taken),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Issued PCs in request order; every response retires one, stale or not.
  // Its occupancy is the in-flight request count.
  fetch_queue #(
    .DEPTH (TRK_DEPTH),
    .W     (32)
  ) u_pending (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (1'b0),
    .push  (grant),
    .pop   (rsp),
    .din   (pc_reg),
    .dout  (trk_head_pc),
    .count (inflight),
    .full  (trk_full),
    .empty (trk_empty)
  );

  assign valid_d    = ~q_empty;
  assign instr_d    = q_empty ? '0 : q_head.instr;
  assign pc_d       = q_empty ? '0 : q_head.pc;
  assign pc_plus8_d = q_empty ? '0 : q_head.pc + PC_READ_OFFSET;

  // The credit rule never lets a response arrive for a full buffer.
  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!reset_n) !(q_push && q_full)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n, stall_d, br_taken;
  logic [31:0] br_target;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pc_plus8_d;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc8;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .stall_d(stall_d), .br_taken(br_taken),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pc_plus8_d(pc_plus8_d)
  );

  // Same control inputs, different reset PC: exercises the address wrap.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset_n(reset_n), .stall_d(stall_d), .br_taken(br_taken),
    .br_target(br_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_d(w_valid), .instr_d(w_instr), .pc_d(w_pc), .pc_plus8_d(w_pc8)
  );

  // ---------------- reference model (transaction level) ----------------
  typedef struct { logic [31:0] pc; bit drop; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { int due; logic [31:0] addr; } rsp_t;

  req_t        pend[$];   // requests the memory still owes, oldest first
  ent_t        q[$];      // instructions waiting for decode
  rsp_t        mq[$];     // memory responder schedule
  logic [31:0] m_pc;
  int          cyc;
  int          vectors, miscompares;
  bit          gnt_always;
  int          lat_min, lat_max, spur_pct;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'hE3A00001;
    if (a == 32'h4) return 32'hE3A01002;
    return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (!pend[i].drop) n++;
    return n;
  endfunction

  function automatic bit m_req();
    return (live_cnt() + q.size()) < DEPTH;
  endfunction

  function automatic bit pending_live(input logic [31:0] a);
    foreach (pend[i]) if (pend[i].pc == a && !pend[i].drop) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [129:0] exp_vec();
    if (q.size() == 0) return {m_req(), m_pc, 1'b0, 96'b0};
    return {m_req(), m_pc, 1'b1, q[0].instr, q[0].pc, q[0].pc + 32'd8};
  endfunction

  function automatic logic [129:0] obs_vec();
    return {imem_req, imem_addr, valid_d, instr_d, pc_d, pc_plus8_d};
  endfunction

  task automatic model_reset();
    pend.delete(); q.delete(); mq.delete();
    m_pc = 32'h0;
  endtask

  // Drive memory inputs for the current cycle, clock once, advance the model.
  task automatic tick();
    bit fire, spur, grant, rsp, pop;
    logic [31:0] old_pc;
    req_t r;
    fire = reset_n && mq.size() > 0 && mq[0].due <= cyc;
    spur = reset_n && !fire && pend.size() == 0 && ($urandom_range(99) < spur_pct);
    imem_gnt    = gnt_always ? 1'b1 : 1'($urandom_range(1));
    imem_rvalid = fire | spur;
    imem_rdata  = fire ? mem_word(mq[0].addr) : $urandom();
    grant = reset_n && m_req() && imem_gnt;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      rsp    = imem_rvalid && pend.size() > 0;
      pop    = q.size() > 0 && !stall_d;
      old_pc = m_pc;
      if (pop) void'(q.pop_front());
      if (rsp) begin
        r = pend.pop_front();
        if (!r.drop && !br_taken) q.push_back('{r.pc, imem_rdata});
      end
      if (fire) void'(mq.pop_front());
      if (grant) begin
        pend.push_back('{old_pc, br_taken});
        mq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), old_pc});
      end
      if (br_taken) begin
        q.delete();
        foreach (pend[i]) pend[i].drop = 1'b1;
        m_pc = br_target & ~32'h3;
      end else if (grant) begin
        m_pc = old_pc + 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall_d = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic set_mem(input bit ga, input int lmin, input int lmax, input int sp);
    gnt_always = ga; lat_min = lmin; lat_max = lmax; spur_pct = sp;
  endtask

  // ------------------------------- tests -------------------------------
  task automatic test_reset();
    set_mem(1, 1, 1, 0);
    reset_n = 1'b0; stall_d = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    tick();
    vectors++;
    if ({imem_req, valid_d, instr_d, pc_d, pc_plus8_d} !== 98'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_zero: got req=%0b valid=%0b instr=%h pc=%h pc8=%h want all 0",
               imem_req, valid_d, instr_d, pc_d, pc_plus8_d);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_first_req: got req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
    end
    for (int i = 0; i < 10 && valid_d !== 1'b1; i++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (valid_d !== 1'b1 || pc_d !== 32'h0 || pc_plus8_d !== 32'h8 || instr_d !== 32'hE3A00001) begin
      miscompares++;
      $display("FAIL reset_first_instr: got v=%0b pc=%h pc8=%h instr=%h want v=1 pc=0 pc8=8 instr=e3a00001",
               valid_d, pc_d, pc_plus8_d, instr_d);
    end
    tick();
    vectors++;
    if (valid_d !== 1'b1 || pc_d !== 32'h4 || instr_d !== 32'hE3A01002) begin
      miscompares++;
      $display("FAIL reset_second_instr: got v=%0b pc=%h instr=%h want v=1 pc=4 instr=e3a01002",
               valid_d, pc_d, instr_d);
    end
  endtask

  task automatic test_backpressure();
    set_mem(1, 1, 1, 0);
    do_reset();
    stall_d = 1'b1;
    repeat (6) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (imem_req !== 1'b0 || valid_d !== 1'b1 || pc_d !== 32'h0) begin
      miscompares++;
      $display("FAIL bp_full: got req=%0b v=%0b pc=%h want req=0 v=1 pc=0", imem_req, valid_d, pc_d);
    end
    stall_d = 1'b0;
    tick();
    vectors++;
    if (imem_req !== 1'b1 || valid_d !== 1'b1 || pc_d !== 32'h4) begin
      miscompares++;
      $display("FAIL bp_release: got req=%0b v=%0b pc=%h want req=1 v=1 pc=4", imem_req, valid_d, pc_d);
    end
    repeat (6) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bp_after c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_redirect_inflight();
    bit found = 1'b0;
    set_mem(1, 3, 3, 0);
    do_reset();
    for (int i = 0; i < 30 && !pending_live(32'h8); i++) tick();
    vectors++;
    if (!pending_live(32'h8)) begin
      miscompares++;
      $display("FAIL redir_setup: fetch of 0x8 never granted, got imem_addr=%h", imem_addr);
    end
    br_taken = 1'b1; br_target = 32'h100;
    tick();
    br_taken = 1'b0;
    vectors++;
    if (valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_flush: got valid_d=%0b want 0", valid_d);
    end
    for (int i = 0; i < 30 && !found; i++) begin
      if (valid_d === 1'b1) begin
        found = 1'b1;
        vectors++;
        if (pc_d !== 32'h100 || pc_plus8_d !== 32'h108) begin
          miscompares++;
          $display("FAIL redir_first: got pc=%h pc8=%h want 00000100/00000108", pc_d, pc_plus8_d);
        end
      end else begin
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL redir_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
        end
      end
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("FAIL redir_timeout: got valid_d=%0b want 1 within 30 cycles", valid_d);
    end
  endtask

  task automatic test_redirect_grant();
    bit found = 1'b0;
    set_mem(1, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 30 && !(m_pc == 32'hC && m_req()); i++) tick();
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      miscompares++;
      $display("FAIL grant_setup: got req=%0b addr=%h want req=1 addr=0000000c", imem_req, imem_addr);
    end
    br_taken = 1'b1; br_target = 32'h203;
    tick();
    br_taken = 1'b0;
    vectors++;
    if (imem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL grant_align: got imem_addr=%h want 00000200", imem_addr);
    end
    for (int i = 0; i < 30 && !found; i++) begin
      if (valid_d === 1'b1) begin
        found = 1'b1;
        vectors++;
        if (pc_d !== 32'h200 || instr_d !== mem_word(32'h200)) begin
          miscompares++;
          $display("FAIL grant_first: got pc=%h instr=%h want 00000200/%h", pc_d, instr_d, mem_word(32'h200));
        end
      end else begin
        tick();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL grant_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
        end
      end
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: got valid_d=%0b want 1 within 30 cycles", valid_d);
    end
  endtask

  task automatic test_wrap();
    set_mem(1, 1, 1, 0);
    do_reset();
    vectors++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_first_addr: got req=%0b addr=%h want 1/fffffffc", w_req, w_addr);
    end
    tick();
    vectors++;
    if (w_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_second_addr: got addr=%h want 00000000", w_addr);
    end
    for (int i = 0; i < 10 && w_valid !== 1'b1; i++) tick();
    vectors++;
    if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pc8 !== 32'h4) begin
      miscompares++;
      $display("FAIL wrap_pc8: got v=%0b pc=%h pc8=%h want 1/fffffffc/00000004", w_valid, w_pc, w_pc8);
    end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    set_mem(1, 3, 3, 0);
    do_reset();
    stall_d = 1'b1;
    for (int i = 0; i < 30 && !(q.size() == 1 && pend.size() >= 1); i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (valid_d !== 1'b0 || imem_req !== 1'b0 || pc_d !== 32'h0 || instr_d !== 32'h0 || pc_plus8_d !== 32'h0) begin
      miscompares++;
      $display("FAIL async_clear: got v=%0b req=%0b pc=%h instr=%h pc8=%h want all 0",
               valid_d, imem_req, pc_d, instr_d, pc_plus8_d);
    end
    stall_d = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_d !== 1'b0) begin
      miscompares++;
      $display("FAIL async_restart: got req=%0b addr=%h v=%0b want 1/00000000/0", imem_req, imem_addr, valid_d);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid_d === 1'b1 && !found) begin
        found = 1'b1;
        vectors++;
        if (pc_d !== 32'h0 || instr_d !== 32'hE3A00001) begin
          miscompares++;
          $display("FAIL async_no_stale: got pc=%h instr=%h want 00000000/e3a00001", pc_d, instr_d);
        end
      end
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL async_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    set_mem(0, 1, 3, 10);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      stall_d   = ($urandom_range(99) < 30);
      br_taken  = ($urandom_range(99) < 6);
      br_target = $urandom();
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
    end
    br_taken = 1'b0; stall_d = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    reset_n = 1'b0; stall_d = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    m_pc = 32'h0;
    set_mem(1, 1, 1, 0);
    test_reset();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_grant();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1ms want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
